keccak_perm_arbiter: RTL and testbench

KECCAK_PERM_ARBITER -- requirements
Module: keccak_perm_arbiter

---
 rtl/keccak_perm_arbiter.sv | 124 ++++++++++++
 tb/tb_keccak_perm_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_perm_arbiter.sv
// Two-requester round-robin front end for a single Keccak-f[1600] permutation core.
// One request in flight; handles issue against a busy core, a bounded wait with timeout, and held responses.
module keccak_perm_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][1599:0]    req_state,
  output logic [1:0]            resp_valid,
  input  logic [1:0]            resp_ready,
  output logic [1599:0]         resp_state,
  output logic                  resp_err,
  output logic                  core_start,
  output logic [1599:0]         core_state_in,
  input  logic                  core_busy,
  input  logic                  core_done,
  input  logic [1599:0]         core_state_out,
  output logic                  err_sticky
);

  localparam int unsigned STATE_W = 1600;
  localparam int unsigned CNT_W   = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e               state_q;
  logic                 ptr_q;
  logic                 grant_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [1:0]           resp_valid_q;
  logic [STATE_W-1:0]   resp_state_q;
  logic                 resp_err_q;
  logic [STATE_W-1:0]   core_state_in_q;
  logic                 err_sticky_q;

  logic [1:0]           gnt_c;
  logic                 gnt_idx_c;

  // Round-robin pick: the pointer only matters when both requesters contend.
  always_comb begin
    gnt_c = 2'b00;
    if (req_valid == 2'b11) begin
      gnt_c = ptr_q ? 2'b10 : 2'b01;
    end else begin
      gnt_c = req_valid;
    end
  end

  assign gnt_idx_c  = gnt_c[1];
  assign req_ready  = (!rst && (state_q == S_IDLE)) ? gnt_c : 2'b00;
  assign core_start = !rst && (state_q == S_ISSUE) && !core_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      ptr_q           <= 1'b0;
      grant_q         <= 1'b0;
      cnt_q           <= '0;
      resp_valid_q    <= 2'b00;
      resp_state_q    <= '0;
      resp_err_q      <= 1'b0;
      core_state_in_q <= '0;
      err_sticky_q    <= 1'b0;
    end else begin
      // A done pulse outside WAIT belongs to no live request (e.g. issued before a reset).
      if (core_done && (state_q != S_WAIT)) begin
        err_sticky_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (|gnt_c) begin
            core_state_in_q <= req_state[gnt_idx_c];
            grant_q         <= gnt_idx_c;
            ptr_q           <= ~gnt_idx_c;
            state_q         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!core_busy) begin
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (core_done) begin
            resp_state_q <= core_state_out;
            resp_err_q   <= 1'b0;
            resp_valid_q <= grant_q ? 2'b10 : 2'b01;
            state_q      <= S_RESP;
          end else if (cnt_q == TIMEOUT_LAST) begin
            resp_err_q   <= 1'b1;
            err_sticky_q <= 1'b1;
            resp_valid_q <= grant_q ? 2'b10 : 2'b01;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (resp_ready[grant_q]) begin
            resp_valid_q <= 2'b00;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_state    = resp_state_q;
  assign resp_err      = resp_err_q;
  assign core_state_in = core_state_in_q;
  assign err_sticky    = err_sticky_q;

endmodule

// File: tb/tb_keccak_perm_arbiter.sv
// Directed bench for keccak_perm_arbiter: transaction-level reference model checked every cycle,
// a behavioural permutation core (result = bitwise inverse of input), and hand-computed latency/data pins.
module tb_keccak_perm_arbiter;

  localparam int TMO = 32;
  localparam logic [1599:0] PAT0 = {25{64'hA5A5_0F0F_1234_5678}};
  localparam logic [1599:0] NOT0 = {25{64'h5A5A_F0F0_EDCB_A987}};
  localparam logic [1599:0] PAT1 = {25{64'h0000_FFFF_3C3C_C3C3}};
  localparam logic [1599:0] NOT1 = {25{64'hFFFF_0000_C3C3_3C3C}};

  logic               clk;
  logic               rst;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0][1599:0] req_state;
  logic [1:0]         resp_valid;
  logic [1:0]         resp_ready;
  logic [1599:0]      resp_state;
  logic               resp_err;
  logic               core_start;
  logic [1599:0]      core_state_in;
  logic               core_busy;
  logic               core_done;
  logic [1599:0]      core_state_out;
  logic               err_sticky;

  keccak_perm_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_state      (req_state),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_state     (resp_state),
    .resp_err       (resp_err),
    .core_start     (core_start),
    .core_state_in  (core_state_in),
    .core_busy      (core_busy),
    .core_done      (core_done),
    .core_state_out (core_state_out),
    .err_sticky     (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_state(input string name, input logic [1599:0] act, input logic [1599:0] exp);
    int lane;
    n_vec++;
    if (act !== exp) begin
      n_err++;
      lane = 0;
      for (int l = 24; l >= 0; l--) begin
        if (act[64*l +: 64] !== exp[64*l +: 64]) lane = l;
      end
      $display("FAIL %s lane %0d: got %h expected %h (cycle %0d)", name, lane,
               act[64*lane +: 64], exp[64*lane +: 64], cyc);
    end
  endtask

  function automatic int arb(input logic [1:0] v, input int p);
    if (v == 2'b11) return p;
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  function automatic logic [1:0] onehot(input int i);
    if (i == 0) return 2'b01;
    if (i == 1) return 2'b10;
    return 2'b00;
  endfunction

  // ---------------- reference model (transaction view) ----------------
  bit            m_init = 0;
  int            m_ptr, m_idx, m_waited;
  bit            m_busy, m_started, m_have_resp, m_resp_err, m_sticky;
  logic [1599:0] m_resp_state, m_core_in;

  initial begin
    int g;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_init = 1; m_ptr = 0; m_idx = 0; m_waited = 0;
        m_busy = 0; m_started = 0; m_have_resp = 0; m_resp_err = 0; m_sticky = 0;
        m_resp_state = '0; m_core_in = '0;
      end else if (m_init) begin
        if (core_done && !(m_busy && m_started && !m_have_resp)) m_sticky = 1;
        if (!m_busy) begin
          g = arb(req_valid, m_ptr);
          if (g >= 0) begin
            m_busy = 1; m_started = 0; m_idx = g; m_ptr = 1 - g; m_core_in = req_state[g];
          end
        end else if (!m_started) begin
          if (!core_busy) begin m_started = 1; m_waited = 0; end
        end else if (!m_have_resp) begin
          m_waited++;
          if (core_done) begin
            m_have_resp = 1; m_resp_err = 0; m_resp_state = core_state_out;
          end else if (m_waited == TMO) begin
            m_have_resp = 1; m_resp_err = 1; m_sticky = 1;
          end
        end else if (resp_ready[m_idx]) begin
          m_busy = 0; m_started = 0; m_have_resp = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare and event log ----------------
  int n_starts = 0;
  int start_cyc = 0;
  int n_resp_cycles = 0;
  int grant_log[$];

  initial begin
    logic [1:0] exp_rr;
    forever begin
      @(negedge clk);
      if (m_init) begin
        exp_rr = (rst || m_busy) ? 2'b00 : onehot(arb(req_valid, m_ptr));
        chk("req_ready", 64'(req_ready), 64'(exp_rr));
        chk("core_start", 64'(core_start), 64'(!rst && m_busy && !m_started && !core_busy));
        chk("resp_valid", 64'(resp_valid), 64'(m_have_resp ? onehot(m_idx) : 2'b00));
        chk("err_sticky", 64'(err_sticky), 64'(m_sticky));
        chk_state("core_state_in", core_state_in, m_core_in);
        if (m_have_resp) begin
          chk("resp_err", 64'(resp_err), 64'(m_resp_err));
          chk_state("resp_state", resp_state, m_resp_state);
        end
      end
      if (core_start) begin n_starts++; start_cyc = cyc; end
      if (|resp_valid) n_resp_cycles++;
      if (|(req_ready & req_valid)) grant_log.push_back(req_ready[1] ? 1 : 0);
    end
  end

  // ---------------- behavioural permutation core ----------------
  int            core_delay = 24;
  logic [1599:0] core_snap;

  initial begin
    core_done = 1'b0;
    core_state_out = '0;
    forever begin
      @(negedge clk);
      if (core_start && core_delay > 0) begin
        core_snap = core_state_in;
        for (int i = 0; i < core_delay; i++) begin @(posedge clk); #1; end
        core_done = 1'b1;
        core_state_out = ~core_snap;
        @(posedge clk); #1;
        core_done = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_rst();
    rst = 1'b1; step(1); rst = 1'b0;
  endtask

  task automatic do_accept(input int idx, output bit ok, output int acc);
    ok = 0; acc = 0;
    req_valid = onehot(idx);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready[idx]) begin ok = 1; acc = cyc; break; end
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
  endtask

  task automatic wait_resp(input int idx, input int budget, output bit ok, output int rc);
    ok = 0; rc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (resp_valid[idx]) begin ok = 1; rc = cyc; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected $finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    bit ok;
    int acc, rc;
    rst = 1'b1; req_valid = 2'b11; resp_ready = 2'b00; core_busy = 1'b0;
    req_state[0] = PAT0; req_state[1] = PAT1;

    // reset values, with both requesters asking
    @(posedge clk); @(negedge clk); #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_core_start", 64'(core_start), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_err_sticky", 64'(err_sticky), 64'd0);
    chk_state("rst_resp_state", resp_state, '0);
    chk_state("rst_core_state_in", core_state_in, '0);
    @(posedge clk); #1;
    req_valid = 2'b00; rst = 1'b0;
    step(1);

    // single request, core finishes 24 cycles after start
    core_delay = 24; resp_ready = 2'b01; n_starts = 0;
    do_accept(0, ok, acc);
    chk("s1_accepted", 64'(ok), 64'd1);
    wait_resp(0, 80, ok, rc);
    chk("s1_resp_seen", 64'(ok), 64'd1);
    chk("s1_start_count", 64'(n_starts), 64'd1);
    chk("s1_start_latency", 64'(start_cyc - acc), 64'd1);
    chk("s1_resp_latency", 64'(rc - start_cyc), 64'd25);
    chk("s1_resp_valid", 64'(resp_valid), 64'd1);
    chk("s1_resp_err", 64'(resp_err), 64'd0);
    chk_state("s1_resp_state", resp_state, NOT0);
    step(3);

    // backpressure on requester 1 while requester 0 waits; wrong-index ready ignored
    core_delay = 3; resp_ready = 2'b00;
    do_accept(1, ok, acc);
    chk("bp_accepted", 64'(ok), 64'd1);
    wait_resp(1, 40, ok, rc);
    chk("bp_resp_seen", 64'(ok), 64'd1);
    @(posedge clk); #1;
    req_valid = 2'b11; resp_ready = 2'b01;
    step(10);
    @(negedge clk); #1;
    chk("bp_resp_valid_held", 64'(resp_valid), 64'd2);
    chk("bp_req_ready_zero", 64'(req_ready), 64'd0);
    chk_state("bp_resp_state_held", resp_state, NOT1);
    @(posedge clk); #1;
    req_valid = 2'b00; resp_ready = 2'b10;
    step(1);
    @(negedge clk); #1;
    chk("bp_released", 64'(resp_valid), 64'd0);
    @(posedge clk); #1;
    resp_ready = 2'b00;
    step(2);

    // contention with both valid held, pointer reset to 0
    pulse_rst();
    core_delay = 2; resp_ready = 2'b11; grant_log.delete(); req_valid = 2'b11;
    for (int i = 0; i < 300 && grant_log.size() < 4; i++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 2'b00;
    step(12);
    chk("rr_grant_count", 64'(grant_log.size()), 64'd4);
    if (grant_log.size() >= 4) begin
      chk("rr_grant0", 64'(grant_log[0]), 64'd0);
      chk("rr_grant1", 64'(grant_log[1]), 64'd1);
      chk("rr_grant2", 64'(grant_log[2]), 64'd0);
      chk("rr_grant3", 64'(grant_log[3]), 64'd1);
    end

    // core busy for 5 cycles while in issue
    pulse_rst();
    core_busy = 1'b1; core_delay = 4; resp_ready = 2'b01; n_starts = 0;
    do_accept(0, ok, acc);
    step(5);
    core_busy = 1'b0;
    wait_resp(0, 40, ok, rc);
    chk("busy_resp_seen", 64'(ok), 64'd1);
    chk("busy_start_count", 64'(n_starts), 64'd1);
    chk("busy_start_latency", 64'(start_cyc - acc), 64'd6);
    step(3);

    // timeout: core never completes
    pulse_rst();
    core_delay = -1; resp_ready = 2'b01; n_starts = 0;
    do_accept(0, ok, acc);
    wait_resp(0, 80, ok, rc);
    chk("tmo_resp_seen", 64'(ok), 64'd1);
    chk("tmo_start_count", 64'(n_starts), 64'd1);
    chk("tmo_resp_latency", 64'(rc - start_cyc), 64'd33);
    chk("tmo_resp_err", 64'(resp_err), 64'd1);
    chk("tmo_err_sticky", 64'(err_sticky), 64'd1);
    chk_state("tmo_resp_state_kept", resp_state, '0);
    step(3);

    // reset mid-wait, then the core's late done must only raise err_sticky
    pulse_rst();
    core_delay = 20; resp_ready = 2'b01;
    do_accept(0, ok, acc);
    step(6);
    rst = 1'b1; step(1); rst = 1'b0;
    n_resp_cycles = 0;
    step(25);
    req_valid = 2'b10;
    @(negedge clk); #1;
    chk("late_err_sticky", 64'(err_sticky), 64'd1);
    chk("late_no_resp", 64'(n_resp_cycles), 64'd0);
    chk("late_resp_valid", 64'(resp_valid), 64'd0);
    chk("late_idle_ready", 64'(req_ready), 64'd2);
    #1 req_valid = 2'b00;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
